bfp_scaler: RTL and testbench
=============================

# bfp_scaler

Block-floating-point scaler for the radix-2 FFT datapath. It consumes the per-butterfly bit widths produced by the BFP width detector and keeps a running maximum over one FFT stage. At each stage boundary it turns that maximum into a right-shift amount. It applies the shift to the butterfly operands of the next stage and accumulates the frame's block exponent. It sits between data-memory read and the butterfly unit.

## Interface
Parameters:
- FFT_DW, 16: operand width, two's complement.
- FFT_BFPDW, 5: width of the bit-width input; must hold 0..FFT_DW.
- FFT_EXPDW, 8: block-exponent width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse; begins a new frame.
- frame_end  in  1  pulse; closes the frame.
- stage_start  in  1  pulse; stage boundary.
- bw_valid  in  1  bw_in is valid this cycle.
- bw_in  in  FFT_BFPDW  detected width of one butterfly output group.
- in_valid  in  1  operands valid this cycle.
- operand0..operand3  in  FFT_DW each  butterfly inputs (re/im of A and B).
- out_valid  out  1  scaled operands valid.
- scaled0..scaled3  out  FFT_DW each  shifted operands.
- shift_amt  out  2  shift in effect for the current stage.
- exponent  out  FFT_EXPDW  accumulated block exponent.
- exp_valid  out  1  frame exponent is final.

## Operation
- Constant TARGET = FFT_DW-2, which leaves 2 bits of headroom for radix-2 complex growth.
- States: IDLE, ACTIVE, DONE.
  - IDLE to ACTIVE on frame_start.
  - ACTIVE to DONE on frame_end.
  - DONE to ACTIVE on frame_start.
  - frame_start from any state: bw_max, shift_amt and exponent go to 0, exp_valid goes to 0.
- Width accumulation, ACTIVE only: on bw_valid, bw_max <= max(bw_max, bw_in). bw_in > FFT_DW is clamped to FFT_DW.
- On stage_start in ACTIVE:
  - s = (bw_max > TARGET) ? bw_max-TARGET : 0, so s is in {0,1,2}.
  - shift_amt <= s.
  - exponent <= exponent + s, saturating at 2^FFT_EXPDW-1.
  - bw_max <= (bw_valid ? clamp(bw_in) : 0). A simultaneous bw_in belongs to the new stage.
- Data path: scaledN = operandN >>> shift_eff, arithmetic shift, truncating toward negative infinity.
  - shift_eff = s when stage_start is asserted in the same cycle, otherwise shift_amt.
  - Operands presented in a stage_start cycle therefore belong to the new stage.
- in_valid in IDLE or DONE is ignored: out_valid stays 0 and scaled outputs hold.
- frame_end in ACTIVE: go to DONE, exp_valid <= 1, exponent frozen.
- stage_start, bw_valid and in_valid in IDLE or DONE: no effect.
- frame_start and frame_end in the same cycle: frame_start wins.
- There is no backpressure; upstream never stalls this block.

## Timing
- Latency: 1 cycle, in_valid/operands to out_valid/scaled. Full throughput, one group per cycle.
- shift_amt and exponent update on the clock edge that samples stage_start, so they are visible the next cycle.
- exp_valid rises the cycle after frame_end and holds until frame_start or rst.
- Reset state:
  - state is IDLE.
  - All outputs are 0: out_valid, scaled0..3, shift_amt, exponent, exp_valid.
  - bw_max is 0.
- Reset mid-frame discards the frame; no residual out_valid appears on the next cycle.

## Structure
- Shared package bfp_pkg holds:
  - the state enum (IDLE/ACTIVE/DONE);
  - a TARGET function of FFT_DW;
  - a function mapping bw to shift.
- Sub-module bfp_arithShifter: combinational FFT_DW arithmetic right shift by 0..2, instantiated four times.
- The top module holds the FSM, bw_max, shift_amt, exponent and the output registers.

## Test plan
All scenarios use FFT_DW=16, so TARGET=14.
- Reset:
  - Stimulus: assert rst mid-stream.
  - Response: next cycle all outputs are 0 and in_valid produces no out_valid.
- Single shift:
  - Stimulus: frame_start; bw 12, 15, 9; stage_start; then in_valid with operand0=0x4000 and operand1=0x8001.
  - Response: shift_amt=1, exponent=1; one cycle later scaled0=0x2000, scaled1=0xC000.
- Max growth:
  - Stimulus: next stage gives bw 16, then stage_start.
  - Response: shift_amt=2, exponent=3; operand 0x7FFF is scaled to 0x1FFF.
- Same-cycle events:
  - Stimulus: bw_max=10; stage_start, bw_valid with bw_in=16 and in_valid with operand0=0x0100, all in one cycle.
  - Response: scaled0=0x0100 (s=0); the following stage_start gives shift_amt=2.
- Frame end:
  - Stimulus: frame_end with exponent=3, then in_valid and stage_start.
  - Response: exp_valid=1 next cycle; exponent stays 3; no out_valid.
- Saturation:
  - Stimulus: FFT_EXPDW=2; three stages each with bw 16.
  - Response: exponent values 2, then 3, then 3.

Source files
------------

// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared types and helpers for the block-floating-point scaler
package bfp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } bfp_state_t;

    // Two bits of headroom absorb radix-2 complex butterfly growth.
    function automatic logic [31:0] bfp_target(input logic [31:0] dw);
        return dw - 32'd2;
    endfunction

    // bw is pre-clamped to dw by the caller, so the result fits in 0..2.
    function automatic logic [1:0] bfp_shift(input logic [31:0] bw, input logic [31:0] dw);
        logic [31:0] diff;
        diff = 32'd0;
        if (bw > bfp_target(dw)) begin
            diff = bw - bfp_target(dw);
        end
        return diff[1:0];
    endfunction

endpackage

// File: rtl/bfp_arithShifter.sv
// rtl/bfp_arithShifter.sv - combinational arithmetic right shift by 0..2
module bfp_arithShifter #(
    parameter int FFT_DW = 16
) (
    input  logic [FFT_DW-1:0] operand,
    input  logic [1:0]        shift,
    output logic [FFT_DW-1:0] result
);

    always_comb begin
        result = FFT_DW'($signed(operand) >>> shift);
    end

endmodule

// File: rtl/bfp_scaler.sv
// rtl/bfp_scaler.sv - per-stage BFP shift selection, operand scaling and block exponent
module bfp_scaler
    import bfp_pkg::*;
#(
    parameter int FFT_DW    = 16,
    parameter int FFT_BFPDW = 5,
    parameter int FFT_EXPDW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 stage_start,
    input  logic                 bw_valid,
    input  logic [FFT_BFPDW-1:0] bw_in,
    input  logic                 in_valid,
    input  logic [FFT_DW-1:0]    operand0,
    input  logic [FFT_DW-1:0]    operand1,
    input  logic [FFT_DW-1:0]    operand2,
    input  logic [FFT_DW-1:0]    operand3,
    output logic                 out_valid,
    output logic [FFT_DW-1:0]    scaled0,
    output logic [FFT_DW-1:0]    scaled1,
    output logic [FFT_DW-1:0]    scaled2,
    output logic [FFT_DW-1:0]    scaled3,
    output logic [1:0]           shift_amt,
    output logic [FFT_EXPDW-1:0] exponent,
    output logic                 exp_valid
);

    localparam logic [FFT_BFPDW-1:0] BW_LIMIT = FFT_BFPDW'(FFT_DW);
    localparam logic [FFT_EXPDW-1:0] EXP_SAT  = {FFT_EXPDW{1'b1}};

    bfp_state_t           state;
    logic [FFT_BFPDW-1:0] bw_max;
    logic [FFT_BFPDW-1:0] bw_clamped;
    logic [FFT_BFPDW-1:0] bw_accum;
    logic [1:0]           stage_shift;
    logic [1:0]           shift_eff;
    logic [FFT_EXPDW:0]   exp_sum;
    logic                 active;
    logic                 stage_event;
    logic                 data_event;
    logic [FFT_DW-1:0]    shifted0;
    logic [FFT_DW-1:0]    shifted1;
    logic [FFT_DW-1:0]    shifted2;
    logic [FFT_DW-1:0]    shifted3;

    always_comb begin
        active      = (state == ST_ACTIVE);
        bw_clamped  = (bw_in > BW_LIMIT) ? BW_LIMIT : bw_in;
        bw_accum    = (bw_clamped > bw_max) ? bw_clamped : bw_max;
        stage_shift = bfp_shift(32'(bw_max), 32'(FFT_DW));
        // frame_start restarts and frame_end freezes, so neither cycle closes a stage.
        stage_event = active && stage_start && !frame_start && !frame_end;
        data_event  = active && in_valid;
        // Operands arriving with stage_start already belong to the new stage.
        shift_eff   = stage_event ? stage_shift : shift_amt;
        exp_sum     = {1'b0, exponent} + (FFT_EXPDW+1)'(stage_shift);
    end

    bfp_arithShifter #(.FFT_DW(FFT_DW)) u_shift0 (.operand(operand0), .shift(shift_eff), .result(shifted0));
    bfp_arithShifter #(.FFT_DW(FFT_DW)) u_shift1 (.operand(operand1), .shift(shift_eff), .result(shifted1));
    bfp_arithShifter #(.FFT_DW(FFT_DW)) u_shift2 (.operand(operand2), .shift(shift_eff), .result(shifted2));
    bfp_arithShifter #(.FFT_DW(FFT_DW)) u_shift3 (.operand(operand3), .shift(shift_eff), .result(shifted3));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bw_max    <= '0;
            shift_amt <= '0;
            exponent  <= '0;
            exp_valid <= 1'b0;
            out_valid <= 1'b0;
            scaled0   <= '0;
            scaled1   <= '0;
            scaled2   <= '0;
            scaled3   <= '0;
        end else begin
            out_valid <= data_event;
            if (data_event) begin
                scaled0 <= shifted0;
                scaled1 <= shifted1;
                scaled2 <= shifted2;
                scaled3 <= shifted3;
            end

            if (frame_start) begin
                state     <= ST_ACTIVE;
                bw_max    <= '0;
                shift_amt <= '0;
                exponent  <= '0;
                exp_valid <= 1'b0;
            end else if (active) begin
                if (frame_end) begin
                    state     <= ST_DONE;
                    exp_valid <= 1'b1;
                end else if (stage_event) begin
                    shift_amt <= stage_shift;
                    exponent  <= exp_sum[FFT_EXPDW] ? EXP_SAT : exp_sum[FFT_EXPDW-1:0];
                    bw_max    <= bw_valid ? bw_clamped : '0;
                end else if (bw_valid) begin
                    bw_max <= bw_accum;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfp_scaler.sv
// tb/tb_bfp_scaler.sv - directed self-checking bench for bfp_scaler
module tb_bfp_scaler;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        frame_end;
    logic        stage_start;
    logic        bw_valid;
    logic [4:0]  bw_in;
    logic        in_valid;
    logic [15:0] operand0, operand1, operand2, operand3;
    logic        out_valid;
    logic [15:0] scaled0, scaled1, scaled2, scaled3;
    logic [1:0]  shift_amt;
    logic [7:0]  exponent;
    logic        exp_valid;
    logic        out_valid_s;
    logic [15:0] scaled0_s, scaled1_s, scaled2_s, scaled3_s;
    logic [1:0]  shift_amt_s;
    logic [1:0]  exponent_s;
    logic        exp_valid_s;

    int checks = 0;
    int errors = 0;

    bfp_scaler #(.FFT_DW(16), .FFT_BFPDW(5), .FFT_EXPDW(8)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .stage_start(stage_start), .bw_valid(bw_valid), .bw_in(bw_in), .in_valid(in_valid),
        .operand0(operand0), .operand1(operand1), .operand2(operand2), .operand3(operand3),
        .out_valid(out_valid), .scaled0(scaled0), .scaled1(scaled1), .scaled2(scaled2),
        .scaled3(scaled3), .shift_amt(shift_amt), .exponent(exponent), .exp_valid(exp_valid)
    );

    bfp_scaler #(.FFT_DW(16), .FFT_BFPDW(5), .FFT_EXPDW(2)) dut_sat (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .stage_start(stage_start), .bw_valid(bw_valid), .bw_in(bw_in), .in_valid(in_valid),
        .operand0(operand0), .operand1(operand1), .operand2(operand2), .operand3(operand3),
        .out_valid(out_valid_s), .scaled0(scaled0_s), .scaled1(scaled1_s), .scaled2(scaled2_s),
        .scaled3(scaled3_s), .shift_amt(shift_amt_s), .exponent(exponent_s), .exp_valid(exp_valid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        frame_start = 1'b0; frame_end = 1'b0; stage_start = 1'b0;
        bw_valid = 1'b0; bw_in = 5'd0; in_valid = 1'b0;
        operand0 = 16'h0; operand1 = 16'h0; operand2 = 16'h0; operand3 = 16'h0;
    endtask

    // One clock edge with the currently driven inputs, then inputs return to idle.
    task automatic step;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic send_bw(input logic [4:0] bw);
        bw_valid = 1'b1; bw_in = bw;
        step();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        step(); step();
        rst = 1'b0;
        checks++;
        if ({out_valid, scaled0, scaled1, scaled2, scaled3, shift_amt, exponent, exp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b s0=%h s1=%h s2=%h s3=%h sh=%0d exp=%0d ev=%b, want all 0",
                     out_valid, scaled0, scaled1, scaled2, scaled3, shift_amt, exponent, exp_valid);
        end
        frame_start = 1'b1; step();
        send_bw(5'd16);
        stage_start = 1'b1; step();
        in_valid = 1'b1; operand0 = 16'h1234; operand3 = 16'h8000; step();
        checks++;
        if (out_valid !== 1'b1 || scaled0 !== 16'h048D || scaled3 !== 16'hE000) begin
            errors++;
            $display("FAIL pre_reset_data: got ov=%b s0=%h s3=%h, want 1 048d e000", out_valid, scaled0, scaled3);
        end
        rst = 1'b1; in_valid = 1'b1; operand0 = 16'h7777; step();
        rst = 1'b0;
        checks++;
        if ({out_valid, scaled0, scaled1, scaled2, scaled3, shift_amt, exponent, exp_valid} !== '0) begin
            errors++;
            $display("FAIL midstream_reset: got ov=%b s0=%h s3=%h sh=%0d exp=%0d ev=%b, want all 0",
                     out_valid, scaled0, scaled3, shift_amt, exponent, exp_valid);
        end
        in_valid = 1'b1; operand0 = 16'h4000; step();
        checks++;
        if (out_valid !== 1'b0 || scaled0 !== 16'h0) begin
            errors++;
            $display("FAIL idle_in_valid: got ov=%b s0=%h, want 0 0000", out_valid, scaled0);
        end
    endtask

    task automatic test_single_shift;
        frame_start = 1'b1; step();
        send_bw(5'd12); send_bw(5'd15); send_bw(5'd9);
        stage_start = 1'b1; step();
        checks++;
        if (shift_amt !== 2'd1 || exponent !== 8'd1) begin
            errors++;
            $display("FAIL single_shift_exp: got sh=%0d exp=%0d, want 1 1", shift_amt, exponent);
        end
        in_valid = 1'b1; operand0 = 16'h4000; operand1 = 16'h8001; operand2 = 16'hFFFF; operand3 = 16'h0003;
        step();
        checks++;
        if (out_valid !== 1'b1 || scaled0 !== 16'h2000 || scaled1 !== 16'hC000 ||
            scaled2 !== 16'hFFFF || scaled3 !== 16'h0001) begin
            errors++;
            $display("FAIL single_shift_data: got ov=%b %h %h %h %h, want 1 2000 c000 ffff 0001",
                     out_valid, scaled0, scaled1, scaled2, scaled3);
        end
    endtask

    task automatic test_max_growth;
        send_bw(5'd16);
        stage_start = 1'b1; step();
        checks++;
        if (shift_amt !== 2'd2 || exponent !== 8'd3) begin
            errors++;
            $display("FAIL max_growth_exp: got sh=%0d exp=%0d, want 2 3", shift_amt, exponent);
        end
        in_valid = 1'b1; operand0 = 16'h7FFF; operand1 = 16'h8000; step();
        checks++;
        if (out_valid !== 1'b1 || scaled0 !== 16'h1FFF || scaled1 !== 16'hE000) begin
            errors++;
            $display("FAIL max_growth_data: got ov=%b s0=%h s1=%h, want 1 1fff e000", out_valid, scaled0, scaled1);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || scaled0 !== 16'h1FFF) begin
            errors++;
            $display("FAIL out_valid_pulse: got ov=%b s0=%h, want 0 1fff", out_valid, scaled0);
        end
    endtask

    task automatic test_same_cycle;
        send_bw(5'd10);
        stage_start = 1'b1; bw_valid = 1'b1; bw_in = 5'd16; in_valid = 1'b1; operand0 = 16'h0100;
        step();
        checks++;
        if (out_valid !== 1'b1 || scaled0 !== 16'h0100 || shift_amt !== 2'd0 || exponent !== 8'd3) begin
            errors++;
            $display("FAIL same_cycle: got ov=%b s0=%h sh=%0d exp=%0d, want 1 0100 0 3",
                     out_valid, scaled0, shift_amt, exponent);
        end
        stage_start = 1'b1; step();
        checks++;
        if (shift_amt !== 2'd2 || exponent !== 8'd5) begin
            errors++;
            $display("FAIL same_cycle_next: got sh=%0d exp=%0d, want 2 5", shift_amt, exponent);
        end
        send_bw(5'd31);
        stage_start = 1'b1; step();
        checks++;
        if (shift_amt !== 2'd2 || exponent !== 8'd7) begin
            errors++;
            $display("FAIL bw_clamp: got sh=%0d exp=%0d, want 2 7", shift_amt, exponent);
        end
    endtask

    task automatic test_frame_end;
        frame_start = 1'b1; step();
        checks++;
        if (exponent !== 8'd0 || shift_amt !== 2'd0 || exp_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_restart: got exp=%0d sh=%0d ev=%b, want 0 0 0", exponent, shift_amt, exp_valid);
        end
        send_bw(5'd16);
        stage_start = 1'b1; step();
        send_bw(5'd15);
        stage_start = 1'b1; step();
        frame_end = 1'b1; step();
        checks++;
        if (exp_valid !== 1'b1 || exponent !== 8'd3 || shift_amt !== 2'd1) begin
            errors++;
            $display("FAIL frame_end: got ev=%b exp=%0d sh=%0d, want 1 3 1", exp_valid, exponent, shift_amt);
        end
        send_bw(5'd16);
        stage_start = 1'b1; in_valid = 1'b1; operand0 = 16'h4444; step();
        stage_start = 1'b1; step();
        checks++;
        if (out_valid !== 1'b0 || exp_valid !== 1'b1 || exponent !== 8'd3 || shift_amt !== 2'd1) begin
            errors++;
            $display("FAIL done_frozen: got ov=%b ev=%b exp=%0d sh=%0d, want 0 1 3 1",
                     out_valid, exp_valid, exponent, shift_amt);
        end
        frame_start = 1'b1; frame_end = 1'b1; step();
        checks++;
        if (exp_valid !== 1'b0 || exponent !== 8'd0) begin
            errors++;
            $display("FAIL start_end_collision: got ev=%b exp=%0d, want 0 0", exp_valid, exponent);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] want_sat [3];
        logic [7:0] want_wide [3];
        want_sat[0] = 2'd2; want_sat[1] = 2'd3; want_sat[2] = 2'd3;
        want_wide[0] = 8'd2; want_wide[1] = 8'd4; want_wide[2] = 8'd6;
        frame_start = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            send_bw(5'd16);
            stage_start = 1'b1; step();
            checks++;
            if (exponent_s !== want_sat[i] || exponent !== want_wide[i]) begin
                errors++;
                $display("FAIL saturation_%0d: got sat=%0d wide=%0d, want %0d %0d",
                         i, exponent_s, exponent, want_sat[i], want_wide[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_shift();
        test_max_growth();
        test_same_cycle();
        test_frame_end();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
